demux_1x2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer; inverse of the datapath 2:1 select mux.
- Accepts one word per cycle from a single valid/ready source.
- Steers each word to output port 0 or 1 by a per-word select bit, holding it in a one-entry output slot until the sink accepts it.
- Sits between a shared producer (e.g. ALU/bus result) and two consumers (e.g. register-file write port and memory write path).

---
 rtl/demux_1x2_stream_if.sv | 42 ++++
 rtl/demux_1x2_stream.sv | 102 ++++++++++
 tb/tb_demux_1x2_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/demux_1x2_stream_if.sv
// Stream bundle for demux_1x2_stream: one valid/ready input stream carrying
// a per-word select bit, and two valid/ready output streams.
// The broadcast input is present only when DEMUX_BCAST_EN is defined.
interface demux_1x2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
`ifdef DEMUX_BCAST_EN
  logic             in_bcast;
`endif
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  // Environment side: drives the source stream and both sink readys.
  modport master (
    output in_data, in_sel, in_valid,
`ifdef DEMUX_BCAST_EN
    output in_bcast,
`endif
    input  in_ready,
    input  out0_data, out0_valid, output out0_ready,
    input  out1_data, out1_valid, output out1_ready
  );

  // Demux side: consumes the source stream, drives both output slots.
  modport slave (
    input  in_data, in_sel, in_valid,
`ifdef DEMUX_BCAST_EN
    input  in_bcast,
`endif
    output in_ready,
    output out0_data, out0_valid, input out0_ready,
    output out1_data, out1_valid, input out1_ready
  );
endinterface

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each word from the source is
// steered by in_sel into a one-entry slot on port 0 or port 1 and held there
// until that port's sink accepts it. Each port counts delivered words.
// Optional feature macro: DEMUX_BCAST_EN adds in_bcast, which loads the same
// word into both slots when both can take it.
module demux_1x2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  demux_1x2_stream_if.slave bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  logic [1:0]       out_ready;
  logic [1:0]       slot_full;
  logic [1:0]       slot_free;
  logic [1:0]       drain;
  logic [1:0]       load_next;
  logic             in_ready_next;
  logic [WIDTH-1:0] slot_data [2];
  logic [CNT_W-1:0] slot_cnt  [2];

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Source acceptance: ready depends combinationally on the targeted slot(s),
  // so a full slot draining this cycle can be refilled on the same edge.
  always_comb begin
    in_ready_next = slot_free[bus.in_sel];
    load_next     = 2'b00;
`ifdef DEMUX_BCAST_EN
    if (bus.in_bcast) begin
      in_ready_next = &slot_free;
      load_next     = {2{bus.in_valid && in_ready_next}};
    end else begin
      load_next[0] = bus.in_valid && in_ready_next && !bus.in_sel;
      load_next[1] = bus.in_valid && in_ready_next &&  bus.in_sel;
    end
`else
    load_next[0] = bus.in_valid && in_ready_next && !bus.in_sel;
    load_next[1] = bus.in_valid && in_ready_next &&  bus.in_sel;
`endif
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      slot_state_t      state_reg;
      logic [WIDTH-1:0] data_reg;
      logic [CNT_W-1:0] cnt_reg;

      assign slot_full[gi] = (state_reg == FULL);
      assign drain[gi]     = slot_full[gi] && out_ready[gi];
      assign slot_free[gi] = !slot_full[gi] || out_ready[gi];
      assign slot_data[gi] = data_reg;
      assign slot_cnt[gi]  = cnt_reg;

      // Slot FSM: a load always wins (fills or refills), otherwise a drain
      // empties the slot; data only changes on a load. Reset discards the
      // held word and suppresses counting of any handshake in that cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (load_next[gi]) begin
                state_reg <= FULL;
                data_reg  <= bus.in_data;
              end
            end
            FULL: begin
              if (load_next[gi]) begin
                data_reg <= bus.in_data;
              end else if (drain[gi]) begin
                state_reg <= EMPTY;
              end
            end
            default: state_reg <= EMPTY;
          endcase
          if (drain[gi]) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign bus.in_ready   = in_ready_next;
  assign bus.out0_valid = slot_full[0];
  assign bus.out1_valid = slot_full[1];
  assign bus.out0_data  = slot_data[0];
  assign bus.out1_data  = slot_data[1];
  assign cnt0           = slot_cnt[0];
  assign cnt1           = slot_cnt[1];

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Directed testbench for demux_1x2_stream (counters built 4 bits wide so the
// wrap is reachable quickly). Inputs change 1 time unit after the rising
// edge; registered outputs are checked at that same point, in_ready is
// checked after the inputs have settled.
module tb_demux_1x2_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  int               checks = 0;
  int               errors = 0;

  demux_1x2_stream_if #(.WIDTH(WIDTH)) bus ();

  demux_1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 2 cycles with a word offered: nothing may load.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    bus.in_sel = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
`ifdef DEMUX_BCAST_EN
    bus.in_bcast = 1'b0;
`endif
    tick();
    tick();
    check("rst_out0_valid", 32'(bus.out0_valid), 32'h0);
    check("rst_out1_valid", 32'(bus.out1_valid), 32'h0);
    check("rst_out0_data", 32'(bus.out0_data), 32'h0);
    check("rst_out1_data", 32'(bus.out1_data), 32'h0);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    check("rst_cnt1", 32'(cnt1), 32'h0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("idle_out0_valid", 32'(bus.out0_valid), 32'h0);
    $display("txn reset: valids=%b%b cnt0=%0d cnt1=%0d", bus.out1_valid, bus.out0_valid, cnt0, cnt1);

    // Steering: A5 to port 0, then 3C to port 1 back to back.
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bus.in_sel = 1'b0;
    #1 check("steer_in_ready0", 32'(bus.in_ready), 32'h1);
    tick();
    check("steer_out0_valid", 32'(bus.out0_valid), 32'h1);
    check("steer_out0_data", 32'(bus.out0_data), 32'hA5);
    check("steer_out1_idle", 32'(bus.out1_valid), 32'h0);
    bus.in_data = 8'h3C;
    bus.in_sel = 1'b1;
    #1 check("steer_in_ready1", 32'(bus.in_ready), 32'h1);
    tick();
    check("steer_out1_valid", 32'(bus.out1_valid), 32'h1);
    check("steer_out1_data", 32'(bus.out1_data), 32'h3C);
    check("steer_out0_drained", 32'(bus.out0_valid), 32'h0);
    check("steer_out0_data_held", 32'(bus.out0_data), 32'hA5);
    check("steer_cnt0", 32'(cnt0), 32'h1);
    bus.in_valid = 1'b0;
    tick();
    check("steer_cnt1", 32'(cnt1), 32'h1);
    check("steer_out1_drained", 32'(bus.out1_valid), 32'h0);
    $display("txn steer: cnt0=%0d cnt1=%0d", cnt0, cnt1);

    // Backpressure on port 0: 11 held, 22 stalls.
    bus.out0_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h11;
    bus.in_sel = 1'b0;
    #1 check("bp_in_ready_empty", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_out0_11", 32'(bus.out0_data), 32'h11);
    check("bp_out0_valid", 32'(bus.out0_valid), 32'h1);
    bus.in_data = 8'h22;
    #1 check("bp_in_ready_stall", 32'(bus.in_ready), 32'h0);
    tick();
    check("bp_out0_stable", 32'(bus.out0_data), 32'h11);
    check("bp_cnt0_hold", 32'(cnt0), 32'h1);

    // Head-of-line: port 0 blocked, a port 1 word still goes through.
    bus.in_data = 8'h77;
    bus.in_sel = 1'b1;
    #1 check("hol_in_ready_sel1", 32'(bus.in_ready), 32'h1);
    tick();
    check("hol_out1_valid", 32'(bus.out1_valid), 32'h1);
    check("hol_out1_77", 32'(bus.out1_data), 32'h77);
    check("hol_out0_unaffected", 32'(bus.out0_data), 32'h11);
    bus.in_data = 8'h22;
    bus.in_sel = 1'b0;
    #1 check("hol_in_ready_sel0", 32'(bus.in_ready), 32'h0);
    tick();
    check("hol_cnt1", 32'(cnt1), 32'h2);
    check("hol_out0_still_11", 32'(bus.out0_data), 32'h11);
    $display("txn hol: out1=%h cnt1=%0d", bus.out1_data, cnt1);

    // Release port 0: 11 drains and 22 loads on the same edge.
    bus.out0_ready = 1'b1;
    #1 check("bp_in_ready_release", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_out0_valid_kept", 32'(bus.out0_valid), 32'h1);
    check("bp_out0_22", 32'(bus.out0_data), 32'h22);
    check("bp_cnt0_2", 32'(cnt0), 32'h2);
    bus.in_valid = 1'b0;
    tick();
    check("bp_cnt0_3", 32'(cnt0), 32'h3);
    check("bp_out0_empty", 32'(bus.out0_valid), 32'h0);
    $display("txn backpressure: cnt0=%0d", cnt0);

    // Counter wrap: clear, then 17 words through port 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap_start_cnt1", 32'(cnt1), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_sel = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 8'(8'h40 + i);
      tick();
    end
    check("wrap_last_data", 32'(bus.out1_data), 32'h50);
    check("wrap_cnt1_16", 32'(cnt1), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    check("wrap_cnt1_17", 32'(cnt1), 32'h1);
    check("wrap_out1_empty", 32'(bus.out1_valid), 32'h0);
    $display("txn wrap: cnt1=%0d", cnt1);

    // Mid-stream reset with port 1 full; its handshake in that cycle is not counted.
    bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    tick();
    check("mrst_out1_full", 32'(bus.out1_valid), 32'h1);
    bus.in_valid = 1'b0;
    bus.out1_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out1_valid", 32'(bus.out1_valid), 32'h0);
    check("mrst_out1_data", 32'(bus.out1_data), 32'h0);
    check("mrst_cnt1", 32'(cnt1), 32'h0);
    $display("txn midreset: out1_valid=%b cnt1=%0d", bus.out1_valid, cnt1);

`ifdef DEMUX_BCAST_EN
    // Broadcast: blocked by full port 1, then lands in both slots.
    bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h44;
    bus.in_sel = 1'b1;
    tick();
    bus.in_bcast = 1'b1;
    bus.in_data = 8'h5A;
    #1 check("bc_in_ready_blocked", 32'(bus.in_ready), 32'h0);
    tick();
    check("bc_out0_idle", 32'(bus.out0_valid), 32'h0);
    bus.out1_ready = 1'b1;
    #1 check("bc_in_ready_free", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    check("bc_out0_5a", 32'(bus.out0_data), 32'h5A);
    check("bc_out1_5a", 32'(bus.out1_data), 32'h5A);
    check("bc_valids", 32'({bus.out1_valid, bus.out0_valid}), 32'h3);
    check("bc_cnt1", 32'(cnt1), 32'h1);
    $display("txn bcast: out0=%h out1=%h", bus.out0_data, bus.out1_data);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
